// File: rtl/pool_stream_scheduler.sv
// Job-level controller for the 2x2 max-pooling stage: validates a job, forwards the
// channel-major INT8 stream to the pooling unit, counts its outputs and reports done/error.
module pool_stream_scheduler #(
    parameter int IMAGE_WIDTH   = 112,
    parameter int MAX_HEIGHT    = 112,
    parameter int MAX_CHANNELS  = 1024,
    parameter int DRAIN_TIMEOUT = 8,
    parameter int HB            = $clog2(MAX_HEIGHT + 1),
    parameter int CB            = $clog2(MAX_CHANNELS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_start,
    input  logic          cfg_abort,
    input  logic [HB-1:0] cfg_height,
    input  logic [CB-1:0] cfg_channels,
    input  logic          cfg_pool_en,
    output logic          busy,
    output logic          done,
    output logic          err_cfg,
    output logic          err_count,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          pu_reset,
    output logic          pu_enable,
    output logic          pu_valid_in,
    output logic [7:0]    pu_data_in,
    input  logic          pu_valid_out,
    output logic [31:0]   out_count,
    output logic [CB-1:0] chan_idx,
    output logic [2:0]    dbg_state_o
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q;
    logic [HB-1:0] height_q;
    logic [CB-1:0] chans_q;
    logic [31:0]   exp_count_q;
    logic [CW-1:0] col_q;
    logic [HB-1:0] row_q;
    logic [CB-1:0] chan_q;
    logic [DW-1:0] drain_q;
    logic [31:0]   out_count_q;
    logic [31:0]   out_count_d;
    logic          busy_q;
    logic          done_q;
    logic          err_cfg_q;
    logic          err_count_q;
    logic          pu_reset_q;
    logic          pu_enable_q;
    logic          s_ready_q;
    logic          pu_valid_in_q;
    logic [7:0]    pu_data_in_q;

    logic          cfg_ok;
    logic          accept;
    logic          last_beat;
    logic [31:0]   h32;
    logic [31:0]   c32;
    logic [31:0]   exp_calc;

    assign cfg_ok = (cfg_height != '0) && (cfg_channels != '0)
                 && (32'(cfg_height) <= 32'(MAX_HEIGHT))
                 && (32'(cfg_channels) <= 32'(MAX_CHANNELS))
                 && !(cfg_pool_en && cfg_height[0]);

    // Valid/ready: a beat transfers on any cycle where s_valid && s_ready; s_valid may
    // toggle freely, s_ready is high exactly while streaming.
    assign accept    = s_valid && s_ready_q;
    assign last_beat = (col_q == CW'(IMAGE_WIDTH - 1))
                    && (row_q == height_q - HB'(1))
                    && (chan_q == chans_q - CB'(1));

    assign h32 = 32'(height_q);
    assign c32 = 32'(chans_q);

    always_comb begin
        exp_calc = 32'(IMAGE_WIDTH) * h32 * c32;
        if (pu_enable_q) begin
            exp_calc = 32'(IMAGE_WIDTH / 2) * (h32 >> 1) * c32;
        end
    end

    always_comb begin
        out_count_d = out_count_q;
        if (state_q == S_LOAD) begin
            out_count_d = {31'b0, pu_valid_out};
        end else if ((state_q == S_STREAM || state_q == S_DRAIN) && pu_valid_out) begin
            out_count_d = out_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            height_q      <= '0;
            chans_q       <= '0;
            exp_count_q   <= '0;
            col_q         <= '0;
            row_q         <= '0;
            chan_q        <= '0;
            drain_q       <= '0;
            out_count_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_cfg_q     <= 1'b0;
            err_count_q   <= 1'b0;
            pu_reset_q    <= 1'b0;
            pu_enable_q   <= 1'b0;
            s_ready_q     <= 1'b0;
            pu_valid_in_q <= 1'b0;
            pu_data_in_q  <= '0;
        end else begin
            done_q        <= 1'b0;
            err_cfg_q     <= 1'b0;
            pu_reset_q    <= 1'b0;
            pu_valid_in_q <= 1'b0;
            out_count_q   <= out_count_d;
            if ((state_q == S_STREAM || state_q == S_DRAIN || state_q == S_DONE)
                && (out_count_q > exp_count_q)) begin
                err_count_q <= 1'b1;
            end
            if (state_q != S_IDLE && cfg_abort) begin
                state_q    <= S_IDLE;
                pu_reset_q <= 1'b1;
                s_ready_q  <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cfg_start) begin
                            if (cfg_ok) begin
                                state_q     <= S_LOAD;
                                busy_q      <= 1'b1;
                                height_q    <= cfg_height;
                                chans_q     <= cfg_channels;
                                pu_enable_q <= cfg_pool_en;
                                pu_reset_q  <= 1'b1;
                                err_count_q <= 1'b0;
                            end else begin
                                err_cfg_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        exp_count_q <= exp_calc;
                        col_q       <= '0;
                        row_q       <= '0;
                        chan_q      <= '0;
                        s_ready_q   <= 1'b1;
                        state_q     <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (accept) begin
                            pu_valid_in_q <= 1'b1;
                            pu_data_in_q  <= s_data;
                            if (last_beat) begin
                                state_q   <= S_DRAIN;
                                s_ready_q <= 1'b0;
                                drain_q   <= '0;
                                col_q     <= '0;
                                row_q     <= '0;
                            end else if (col_q == CW'(IMAGE_WIDTH - 1)) begin
                                col_q <= '0;
                                if (row_q == height_q - HB'(1)) begin
                                    row_q  <= '0;
                                    chan_q <= chan_q + CB'(1);
                                end else begin
                                    row_q <= row_q + HB'(1);
                                end
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (out_count_q == exp_count_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (drain_q == DW'(DRAIN_TIMEOUT - 1)) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            err_count_q <= 1'b1;
                        end else begin
                            drain_q <= drain_q + DW'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_cfg     = err_cfg_q;
    assign err_count   = err_count_q;
    assign s_ready     = s_ready_q;
    assign pu_reset    = pu_reset_q;
    assign pu_enable   = pu_enable_q;
    assign pu_valid_in = pu_valid_in_q;
    assign pu_data_in  = pu_data_in_q;
    assign out_count   = out_count_q;
    assign chan_idx    = chan_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pool_stream_scheduler.sv
// Directed bench for pool_stream_scheduler with IMAGE_WIDTH=4 and a small behavioural
// pooling-unit stub that can drop one output per job.
module tb_pool_stream_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start, cfg_abort, cfg_pool_en;
    logic [6:0]  cfg_height;
    logic [10:0] cfg_channels;
    logic        busy, done, err_cfg, err_count;
    logic        s_valid, s_ready;
    logic [7:0]  s_data;
    logic        pu_reset, pu_enable, pu_valid_in, pu_valid_out;
    logic [7:0]  pu_data_in;
    logic [31:0] out_count;
    logic [10:0] chan_idx;
    logic [2:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    pool_stream_scheduler #(
        .IMAGE_WIDTH(4), .MAX_HEIGHT(112), .MAX_CHANNELS(1024), .DRAIN_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_height(cfg_height), .cfg_channels(cfg_channels), .cfg_pool_en(cfg_pool_en),
        .busy(busy), .done(done), .err_cfg(err_cfg), .err_count(err_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .pu_reset(pu_reset), .pu_enable(pu_enable),
        .pu_valid_in(pu_valid_in), .pu_data_in(pu_data_in), .pu_valid_out(pu_valid_out),
        .out_count(out_count), .chan_idx(chan_idx), .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pooling-unit stub ----------------
    logic [1:0] pu_col;
    logic       pu_row, dropped;
    logic       drop_en;

    always @(posedge clk) begin
        if (reset || pu_reset) begin
            pu_col <= 2'd0; pu_row <= 1'b0; pu_valid_out <= 1'b0; dropped <= 1'b0;
        end else begin
            pu_valid_out <= 1'b0;
            if (pu_valid_in) begin
                pu_col <= pu_col + 2'd1;
                if (pu_col == 2'd3) pu_row <= ~pu_row;
                if (!pu_enable || (pu_col[0] && pu_row)) begin
                    if (drop_en && !dropped) dropped <= 1'b1;
                    else pu_valid_out <= 1'b1;
                end
            end
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    logic [7:0] acc_data_q[$];
    int         acc_cyc_q[$];
    logic [7:0] fwd_data_q[$];
    int         fwd_cyc_q[$];
    int done_cnt = 0, pv_cnt = 0, pu_rst_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (s_valid && s_ready) begin acc_data_q.push_back(s_data); acc_cyc_q.push_back(cyc); end
            if (pu_valid_in) begin fwd_data_q.push_back(pu_data_in); fwd_cyc_q.push_back(cyc); end
            if (done) done_cnt++;
            if (pu_valid_out) pv_cnt++;
            if (pu_reset) pu_rst_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input int h, input int c, input bit pool);
        cfg_height = 7'(h); cfg_channels = 11'(c); cfg_pool_en = pool;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic send_pixels(input int n, input logic [7:0] first, input bit toggle);
        int sent = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit acc;
        while (sent < n && guard < 200) begin
            s_valid = toggle ? ph : 1'b1;
            s_data  = s_valid ? first + 8'(sent) : 8'hEE;
            acc     = s_valid && s_ready;
            step();
            if (acc) sent++;
            ph = ~ph;
            guard++;
        end
        s_valid = 1'b0; s_data = 8'h00;
        if (sent < n) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: accepted %0d beats, required %0d", sent, n);
        end
    endtask

    task automatic wait_done(input int target, output int done_c, output int hit_c);
        done_c = -1; hit_c = -1;
        for (int i = 0; i < 60; i++) begin
            if (hit_c < 0 && out_count == 32'(target)) hit_c = cyc;
            if (done) begin done_c = cyc; break; end
            step();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_cmp++; if ({busy, done, err_cfg, err_count, s_ready} !== 5'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {busy, done, err_cfg, err_count, s_ready}); end
        n_cmp++; if ({pu_reset, pu_enable, pu_valid_in, pu_data_in} !== 11'b0) begin n_fail++;
            $display("FAIL reset_pu: got %b required 0", {pu_reset, pu_enable, pu_valid_in, pu_data_in}); end
        n_cmp++; if (out_count !== 32'd0 || chan_idx !== 11'd0 || dbg_state !== 3'd0) begin n_fail++;
            $display("FAIL reset_counters: out_count=%0d chan=%0d state=%0d required 0", out_count, chan_idx, dbg_state); end
    endtask

    task automatic test_pool_basic();
        int ab = acc_data_q.size();
        int fb = fwd_data_q.size();
        int pb = pv_cnt;
        int done_c, hit_c;
        start_job(2, 1, 1);
        n_cmp++; if (dbg_state !== 3'd1 || busy !== 1'b1 || pu_reset !== 1'b1 || pu_enable !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL pool_load: state=%0d busy=%b pu_reset=%b pu_en=%b s_ready=%b required 1/1/1/1/0",
                               dbg_state, busy, pu_reset, pu_enable, s_ready); end
        step();
        n_cmp++; if (s_ready !== 1'b1 || pu_reset !== 1'b0 || out_count !== 32'd0) begin n_fail++;
            $display("FAIL pool_stream_entry: s_ready=%b pu_reset=%b out_count=%0d required 1/0/0", s_ready, pu_reset, out_count); end
        send_pixels(8, 8'd1, 1'b0);
        n_cmp++; if (acc_data_q.size() - ab != 8 || acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[ab] != 7) begin n_fail++;
            $display("FAIL pool_no_stall: beats=%0d span=%0d required 8/7", acc_data_q.size() - ab,
                     acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[ab]); end
        wait_done(2, done_c, hit_c);
        n_cmp++; if (done_c < 0 || hit_c < 0 || done_c != hit_c + 1) begin n_fail++;
            $display("FAIL pool_done_timing: done at %0d, count hit at %0d, required hit+1", done_c, hit_c); end
        n_cmp++; if (out_count !== 32'd2 || err_count !== 1'b0 || pv_cnt - pb != 2) begin n_fail++;
            $display("FAIL pool_result: out_count=%0d err_count=%b pu_outs=%0d required 2/0/2", out_count, err_count, pv_cnt - pb); end
        n_cmp++; if (fwd_data_q.size() - fb != 8) begin n_fail++;
            $display("FAIL pool_fwd_count: got %0d required 8", fwd_data_q.size() - fb); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (fwd_data_q[fb+i] !== 8'(i + 1) || fwd_cyc_q[fb+i] != acc_cyc_q[ab+i] + 1) begin n_fail++;
                    $display("FAIL pool_fwd[%0d]: data=%0d lag=%0d required %0d/1", i, fwd_data_q[fb+i],
                             fwd_cyc_q[fb+i] - acc_cyc_q[ab+i], i + 1); end
            end
        end
        step();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== 3'd0) begin n_fail++;
            $display("FAIL pool_idle_after: busy=%b done=%b state=%0d required 0/0/0", busy, done, dbg_state); end
    endtask

    task automatic test_bypass();
        int ab = acc_data_q.size();
        int fb = fwd_data_q.size();
        int done_c, hit_c;
        start_job(2, 2, 0);
        n_cmp++; if (pu_enable !== 1'b0 || out_count !== 32'd2) begin n_fail++;
            $display("FAIL byp_load: pu_en=%b out_count=%0d required 0/2", pu_enable, out_count); end
        step();
        n_cmp++; if (out_count !== 32'd0) begin n_fail++;
            $display("FAIL byp_count_clear: got %0d required 0", out_count); end
        send_pixels(8, 8'd9, 1'b0);
        n_cmp++; if (chan_idx !== 11'd1) begin n_fail++;
            $display("FAIL byp_chan_idx: got %0d required 1", chan_idx); end
        send_pixels(8, 8'd17, 1'b0);
        wait_done(16, done_c, hit_c);
        n_cmp++; if (done_c < 0 || out_count !== 32'd16 || err_count !== 1'b0 || pu_enable !== 1'b0) begin n_fail++;
            $display("FAIL byp_result: done_cyc=%0d out_count=%0d err=%b pu_en=%b required done/16/0/0",
                     done_c, out_count, err_count, pu_enable); end
        n_cmp++; if (fwd_data_q.size() - fb != 16 || acc_data_q.size() - ab != 16) begin n_fail++;
            $display("FAIL byp_fwd_count: fwd=%0d acc=%0d required 16/16", fwd_data_q.size() - fb, acc_data_q.size() - ab); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++; if (fwd_data_q[fb+i] !== 8'(i + 9) || fwd_cyc_q[fb+i] != acc_cyc_q[ab+i] + 1) begin n_fail++;
                    $display("FAIL byp_fwd[%0d]: data=%0d lag=%0d required %0d/1", i, fwd_data_q[fb+i],
                             fwd_cyc_q[fb+i] - acc_cyc_q[ab+i], i + 9); end
            end
        end
        step();
    endtask

    task automatic test_cfg_reject();
        int hs[5] = '{3, 2, 0, 113, 2};
        int cs[5] = '{1, 0, 1, 1, 1025};
        bit ps[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            int prc = pu_rst_cnt;
            start_job(hs[k], cs[k], ps[k]);
            n_cmp++; if (err_cfg !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin n_fail++;
                $display("FAIL cfg_reject[%0d]: err_cfg=%b busy=%b state=%0d required 1/0/0", k, err_cfg, busy, dbg_state); end
            step();
            n_cmp++; if (err_cfg !== 1'b0 || busy !== 1'b0 || pu_rst_cnt != prc) begin n_fail++;
                $display("FAIL cfg_reject_after[%0d]: err_cfg=%b busy=%b pu_resets=%0d required 0/0/0", k, err_cfg, busy, pu_rst_cnt - prc); end
        end
    endtask

    task automatic test_toggle();
        int ab = acc_data_q.size();
        int fb = fwd_data_q.size();
        int done_c, hit_c;
        start_job(2, 1, 1);
        step();
        send_pixels(8, 8'h40, 1'b1);
        wait_done(2, done_c, hit_c);
        n_cmp++; if (done_c < 0 || out_count !== 32'd2 || err_count !== 1'b0) begin n_fail++;
            $display("FAIL tog_result: done_cyc=%0d out_count=%0d err=%b required done/2/0", done_c, out_count, err_count); end
        n_cmp++; if (fwd_data_q.size() - fb != 8 || acc_data_q.size() - ab != 8) begin n_fail++;
            $display("FAIL tog_fwd_count: fwd=%0d acc=%0d required 8/8", fwd_data_q.size() - fb, acc_data_q.size() - ab); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (fwd_data_q[fb+i] !== 8'h40 + 8'(i) || fwd_cyc_q[fb+i] != acc_cyc_q[ab+i] + 1) begin n_fail++;
                    $display("FAIL tog_fwd[%0d]: data=%h lag=%0d required %h/1", i, fwd_data_q[fb+i],
                             fwd_cyc_q[fb+i] - acc_cyc_q[ab+i], 8'h40 + 8'(i)); end
            end
        end
        step();
    endtask

    task automatic test_abort();
        int prd = done_cnt;
        int prc = pu_rst_cnt;
        int done_c, hit_c;
        start_job(2, 1, 1);
        step();
        send_pixels(5, 8'd1, 1'b0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        n_cmp++; if (dbg_state !== 3'd0 || busy !== 1'b0 || s_ready !== 1'b0 || pu_reset !== 1'b1) begin n_fail++;
            $display("FAIL abort_now: state=%0d busy=%b s_ready=%b pu_reset=%b required 0/0/0/1", dbg_state, busy, s_ready, pu_reset); end
        step();
        n_cmp++; if (pu_reset !== 1'b0 || pu_rst_cnt - prc != 2) begin n_fail++;
            $display("FAIL abort_pulse: pu_reset=%b pulses=%0d required 0/2", pu_reset, pu_rst_cnt - prc); end
        repeat (4) step();
        n_cmp++; if (done_cnt != prd) begin n_fail++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", done_cnt - prd); end
        start_job(2, 1, 1);
        step();
        send_pixels(8, 8'd50, 1'b0);
        wait_done(2, done_c, hit_c);
        n_cmp++; if (done_c < 0 || out_count !== 32'd2 || err_count !== 1'b0) begin n_fail++;
            $display("FAIL abort_next_job: done_cyc=%0d out_count=%0d err=%b required done/2/0", done_c, out_count, err_count); end
        step();
    endtask

    task automatic test_timeout();
        int done_c, hit_c, la, prd;
        drop_en = 1'b1;
        start_job(2, 1, 1);
        step();
        send_pixels(8, 8'd1, 1'b0);
        la = acc_cyc_q[acc_cyc_q.size()-1];
        wait_done(1, done_c, hit_c);
        n_cmp++; if (done_c < 0 || done_c - la != 9) begin n_fail++;
            $display("FAIL tmo_timing: done %0d cycles after last beat, required 9", done_c - la); end
        n_cmp++; if (out_count !== 32'd1 || err_count !== 1'b1) begin n_fail++;
            $display("FAIL tmo_result: out_count=%0d err_count=%b required 1/1", out_count, err_count); end
        step();
        drop_en = 1'b0;
        n_cmp++; if (err_count !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL tmo_sticky: err_count=%b busy=%b required 1/0", err_count, busy); end
        prd = done_cnt;
        start_job(2, 1, 1);
        n_cmp++; if (err_count !== 1'b0) begin n_fail++;
            $display("FAIL tmo_err_clear: err_count=%b required 0", err_count); end
        step();
        send_pixels(2, 8'd1, 1'b0);
        cfg_start = 1'b1; cfg_abort = 1'b1;
        step();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        n_cmp++; if (dbg_state !== 3'd0 || busy !== 1'b0 || pu_reset !== 1'b1 || s_ready !== 1'b0) begin n_fail++;
            $display("FAIL start_abort: state=%0d busy=%b pu_reset=%b s_ready=%b required 0/0/1/0", dbg_state, busy, pu_reset, s_ready); end
        repeat (3) step();
        n_cmp++; if (dbg_state !== 3'd0 || done_cnt != prd) begin n_fail++;
            $display("FAIL start_abort_after: state=%0d done pulses=%0d required 0/0", dbg_state, done_cnt - prd); end
    endtask

    task automatic test_midjob_reset();
        start_job(2, 2, 0);
        step();
        send_pixels(3, 8'd1, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || dbg_state !== 3'd0 || out_count !== 32'd0 || pu_enable !== 1'b0
                     || s_ready !== 1'b0 || chan_idx !== 11'd0) begin n_fail++;
            $display("FAIL midjob_reset: busy=%b state=%0d out_count=%0d pu_en=%b s_ready=%b chan=%0d required all 0",
                     busy, dbg_state, out_count, pu_enable, s_ready, chan_idx); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_pool_en = 1'b0;
        cfg_height = 7'd0; cfg_channels = 11'd0; s_valid = 1'b0; s_data = 8'h00; drop_en = 1'b0;
        test_reset();
        test_pool_basic();
        test_bypass();
        test_cfg_reject();
        test_toggle();
        test_abort();
        test_timeout();
        test_midjob_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
